// File: rtl/vga_sync_decoder_if.sv
// Video sync inputs and recovered-coordinate outputs of the VGA sync decoder.
// Err_Cnt is present only when VGA_SYNC_DECODER_ERRCNT_EN is defined.
interface vga_sync_decoder_if;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic [9:0] Rx_X;
    logic [9:0] Rx_Y;
    logic       Rx_Active;
    logic       Locked;
    logic       Frame_Start;
    logic       Sync_Err;
    logic       Blank_Err;
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    logic [7:0] Err_Cnt;
`endif

    modport master (
        output VGA_HS, VGA_VS, VGA_BLANK_N,
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
        input  Err_Cnt,
`endif
        input  Rx_X, Rx_Y, Rx_Active, Locked, Frame_Start, Sync_Err, Blank_Err
    );

    modport slave (
        input  VGA_HS, VGA_VS, VGA_BLANK_N,
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
        output Err_Cnt,
`endif
        output Rx_X, Rx_Y, Rx_Active, Locked, Frame_Start, Sync_Err, Blank_Err
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// Sink-side VGA sync decoder: locks to HS/VS, recovers X/Y and flags raster violations.
// Define VGA_SYNC_DECODER_ERRCNT_EN to add the saturating Err_Cnt output.
//
// state  | meaning
// HUNT_H | waiting for an HS fall to align X
// HUNT_V | X aligned, waiting for a VS fall to align Y
// LOCKED | aligned; every sync edge and BLANK_N is checked
module vga_sync_decoder #(
    parameter int H_TOTAL      = 800,
    parameter int V_TOTAL      = 525,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_END   = 752,
    parameter int V_SYNC_START = 490
) (
    input  logic              Clk,
    input  logic              Reset_N,
    input  logic              Pix_En,
    vga_sync_decoder_if.slave bus
);
    localparam logic [9:0] HT_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] VT_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] HA      = 10'(H_ACTIVE);
    localparam logic [9:0] VA      = 10'(V_ACTIVE);
    localparam logic [9:0] HSS     = 10'(H_SYNC_START);
    localparam logic [9:0] HSE     = 10'(H_SYNC_END);
    localparam logic [9:0] VSS     = 10'(V_SYNC_START);

    typedef enum logic [1:0] {
        HUNT_H = 2'd0,
        HUNT_V = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t     state, state_d;
    logic       s1_hs, s1_vs, s1_bn, s2_hs, s2_vs;
    logic       hs_fall, hs_rise, vs_fall;
    logic [9:0] rx_x, rx_y, x_inc, y_inc, x_d, y_d;
    logic       sync_err, blank_err, sync_err_d, blank_err_d;

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            s1_hs <= 1'b1;
            s1_vs <= 1'b1;
            s1_bn <= 1'b0;
            s2_hs <= 1'b1;
            s2_vs <= 1'b1;
        end else if (Pix_En) begin
            s1_hs <= bus.VGA_HS;
            s1_vs <= bus.VGA_VS;
            s1_bn <= bus.VGA_BLANK_N;
            s2_hs <= s1_hs;
            s2_vs <= s1_vs;
        end
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N)
            state <= HUNT_H;
        else if (Pix_En)
            state <= state_d;
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            rx_x      <= '0;
            rx_y      <= '0;
            sync_err  <= 1'b0;
            blank_err <= 1'b0;
        end else if (Pix_En) begin
            rx_x      <= x_d;
            rx_y      <= y_d;
            sync_err  <= sync_err_d;
            blank_err <= blank_err_d;
        end
    end

    // x_inc/y_inc are the coordinates of the sample now sitting in s1
    always_comb begin
        hs_fall = s2_hs & ~s1_hs;
        hs_rise = ~s2_hs & s1_hs;
        vs_fall = s2_vs & ~s1_vs;
        x_inc   = (rx_x == HT_LAST) ? 10'd0 : rx_x + 10'd1;
        if (rx_x == HT_LAST)
            y_inc = (rx_y == VT_LAST) ? 10'd0 : rx_y + 10'd1;
        else
            y_inc = rx_y;
    end

    always_comb begin
        state_d     = state;
        x_d         = x_inc;
        y_d         = y_inc;
        sync_err_d  = 1'b0;
        blank_err_d = 1'b0;
        case (state)
            HUNT_H: begin
                if (hs_fall) begin
                    x_d     = HSS;
                    state_d = HUNT_V;
                end
            end
            HUNT_V: begin
                if (vs_fall) begin
                    if (x_inc == 10'd0) begin
                        x_d     = 10'd0;
                        y_d     = VSS;
                        state_d = LOCKED;
                    end else begin
                        sync_err_d = 1'b1;
                        state_d    = HUNT_H;
                    end
                end else if (hs_fall && (x_inc != HSS)) begin
                    sync_err_d = 1'b1;
                    x_d        = HSS;
                end
            end
            LOCKED: begin
                // a missing HS fall at HSS is as much a violation as a misplaced one
                if ((hs_fall != (x_inc == HSS)) ||
                    (hs_rise && (x_inc != HSE)) ||
                    (vs_fall && !((x_inc == 10'd0) && (y_inc == VSS)))) begin
                    sync_err_d = 1'b1;
                    state_d    = HUNT_H;
                end
                blank_err_d = s1_bn != ((x_inc < HA) && (y_inc < VA));
            end
            default: state_d = HUNT_H;
        endcase
    end

    always_comb begin
        bus.Rx_X        = rx_x;
        bus.Rx_Y        = rx_y;
        bus.Locked      = (state == LOCKED);
        bus.Rx_Active   = (state == LOCKED) && (rx_x < HA) && (rx_y < VA);
        bus.Frame_Start = (state == LOCKED) && (rx_x == 10'd0) && (rx_y == 10'd0);
        bus.Sync_Err    = sync_err;
        bus.Blank_Err   = blank_err;
    end

`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    logic [7:0] err_cnt;
    logic [8:0] err_sum;

    assign err_sum = {1'b0, err_cnt} + {8'd0, sync_err_d} + {8'd0, blank_err_d};

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N)
            err_cnt <= '0;
        else if (Pix_En)
            err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    assign bus.Err_Cnt = err_cnt;
`endif
endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Sink-side decoder for the 640x480 VGA timing the display controller produces. It takes HS, VS and BLANK_N and recovers the pixel coordinates.
- It locks to the sync pattern and flags any sync or blanking that departs from the 800x525 raster.
- It sits on the pixel-clock side for on-board self-check and for the verification bench. It also serves as the front end for a frame grabber.

Parameters:
- H_TOTAL, 800, pixels per line including porches
- V_TOTAL, 525, lines per frame
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines
- H_SYNC_START, 656, X of first HS-low pixel
- H_SYNC_END, 752, X of first HS-high pixel after the pulse
- V_SYNC_START, 490, Y of first VS-low line

Ports:
- Clk  in  1  system clock
- Reset_N  in  1  asynchronous active-low reset
- Pix_En  in  1  pixel strobe; logic advances only when 1 (tie to 1 if Clk is the pixel clock)
- VGA_HS  in  1  horizontal sync, active low
- VGA_VS  in  1  vertical sync, active low
- VGA_BLANK_N  in  1  blanking, active low
- Rx_X  out  10  recovered horizontal coordinate
- Rx_Y  out  10  recovered vertical coordinate
- Rx_Active  out  1  Locked and Rx_X<H_ACTIVE and Rx_Y<V_ACTIVE
- Locked  out  1  decoder aligned to raster
- Frame_Start  out  1  one-Pix_En pulse at Rx_X==0, Rx_Y==0 while Locked
- Sync_Err  out  1  one-Pix_En pulse on sync edge at wrong position
- Blank_Err  out  1  one-Pix_En pulse on BLANK_N disagreeing with coordinates

Behaviour:
- Reset (async, Reset_N=0):
  - all outputs 0; state HUNT_H
  - input sample registers reset to HS=1, VS=1, BLANK_N=0
- Pix_En=0: every register holds; pulses stay asserted at most one Pix_En-qualified cycle.
- Stage 1: VGA_HS/VS/BLANK_N registered on each Pix_En (s1).
- Edge detection compares s1 with its previous value (s2):
  - HS fall = s2 HS 1, s1 HS 0
  - HS rise = s2 HS 0, s1 HS 1
  - VS fall = s2 VS 1, s1 VS 0
- Latency: coordinate/flag outputs in Pix_En cycle n describe the input sample taken at Pix_En cycle n-1.
- Counter update (every Pix_En):
  - Rx_X increments; H_TOTAL-1 wraps to 0
  - on wrap, Rx_Y increments; V_TOTAL-1 wraps to 0
  - widths 10 bits; no other overflow possible
- Counter overrides take priority over increment:
  - HS fall in HUNT_H loads Rx_X=H_SYNC_START
  - VS fall in HUNT_V loads Rx_Y=V_SYNC_START and Rx_X=0
- State HUNT_H: Locked=0. On HS fall: load Rx_X, go HUNT_V.
- State HUNT_V: Locked=0; X free-runs.
  - HS fall with next Rx_X != H_SYNC_START: Sync_Err pulse, reload Rx_X=H_SYNC_START, stay in HUNT_V.
  - VS fall: requires next Rx_X==0. If so, load Rx_Y, go LOCKED. Otherwise Sync_Err, go HUNT_H.
- State LOCKED: Locked=1. Checks are made against the coordinate being output this cycle:
  - HS fall only at X==H_SYNC_START
  - HS rise only at X==H_SYNC_END
  - VS fall only at X==0, Y==V_SYNC_START
  - missing HS fall when X==H_SYNC_START also counts as an error
  - any violation: Sync_Err pulse, Locked=0 next cycle, go HUNT_H
  - BLANK_N must equal (X<H_ACTIVE and Y<V_ACTIVE); mismatch pulses Blank_Err only, state unchanged
- Simultaneous Sync_Err and Blank_Err both assert. Blank_Err is never raised outside LOCKED.
- Frame_Start requires LOCKED in the same cycle.
- The first frame after locking is fully checked.

Optional Feature:
- Macro VGA_SYNC_DECODER_ERRCNT_EN.
- When defined:
  - extra output Err_Cnt [7:0] counts Sync_Err and Blank_Err pulses
  - both pulses in one cycle count 2
  - saturates at 255
  - cleared only by reset
- When undefined: port absent, no counter logic.

Test Plan:
- Drive a standard 800x525 raster from reset, Pix_En=1:
  - Locked rises on the cycle after the first VS fall is seen
  - Frame_Start at (0,0) every 420000 cycles thereafter
  - Rx_X/Rx_Y match the generator delayed 1 cycle
- Shift one HS fall to pixel 655 in a locked frame:
  - Sync_Err pulses once; Locked drops
  - relock on the next VS fall with no further errors
- Force BLANK_N=0 at (100,100) for 1 pixel: Blank_Err pulses once; Locked stays 1; Rx_X/Rx_Y continue unchanged.
- Pix_En toggling every other Clk with the raster advancing only on Pix_En: identical coordinate sequence; outputs hold between strobes.
- Assert Reset_N=0 mid-line at (300,200):
  - outputs 0 immediately (async)
  - after release, HUNT_H → HUNT_V → LOCKED within one frame
- With VGA_SYNC_DECODER_ERRCNT_EN defined, inject 300 blank errors: Err_Cnt reads 255 and holds.
